// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: datapath width, reset PC, NOP encoding
// and the common address/instruction types.
package core_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [31:0]     instr_t;

  localparam addr_t  RESET_PC  = '0;
  localparam instr_t NOP_INSTR = 32'h0000_0013;

  // Sequential successor of a PC; wraps modulo 2^XLEN.
  function automatic addr_t pcPlus4(input addr_t pc);
    return pc + addr_t'(4);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with redirect mux, +4 incrementer and a sticky flag for
// misaligned redirect targets.
module pc_reg
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] PCF,
  output logic            MisalignF
);

  // A redirect wins over a fetch stall; the low two target bits are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PCF <= RESET_PC;
    end else if (PCSrcE) begin
      PCF <= {PCTargetE[XLEN-1:2], 2'b00};
    end else if (StallF) begin
      PCF <= pcPlus4(PCF);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MisalignF <= 1'b0;
    end else if (PCSrcE && (PCTargetE[1:0] != 2'b00)) begin
      MisalignF <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage plus IF/ID register with an instruction skid buffer that keeps
// InstrD stable across Decode stalls. Optional counters under FETCH_PERF_EN.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = core_pkg::RESET_PC,
  parameter logic [31:0]     NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] PCF,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            MisalignF
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0] fetch_cnt,
  output logic [XLEN-1:0] stall_cnt
`endif
);

  logic        hold_vld;
  logic [31:0] instr_hold;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .StallF   (StallF),
    .PCSrcE   (PCSrcE),
    .PCTargetE(PCTargetE),
    .PCF      (PCF),
    .MisalignF(MisalignF)
  );

  assign imem_addr = PCF;

  // StallD is an active-low load enable; flush beats it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      PCD      <= PCF;
      PCPlus4D <= pcPlus4(PCF);
      ValidD   <= 1'b1;
    end
  end

  // The memory word belonging to PCD is only on imem_rdata in the first stall
  // cycle; latch it then so a moving imem_addr cannot disturb Decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld   <= 1'b0;
      instr_hold <= '0;
    end else if (FlushD || StallD) begin
      hold_vld <= 1'b0;
    end else if (!hold_vld) begin
      instr_hold <= imem_rdata;
      hold_vld   <= 1'b1;
    end
  end

  assign InstrD = ValidD ? (hold_vld ? instr_hold : imem_rdata) : NOP_INSTR;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (!FlushD && StallD) fetch_cnt <= fetch_cnt + 1'b1;
      if (!FlushD && !StallD) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  // Build without performance counters: no extra state or ports.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with RESET_PC=0x100 and a synchronous ROM model.
// Counter checks are compiled in when FETCH_PERF_EN is defined.
module tb_fetch_stage;
  import core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD, MisalignF;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  fetch_stage #(
    .RESET_PC(32'h0000_0100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .PCF       (PCF),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .MisalignF (MisalignF)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: one real instruction at 0x100, elsewhere addi x0,x0,addr[11:0]
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[11:0], 20'h00013};
  endfunction

  always @(posedge clk) imem_rdata <= memWord(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Driver: apply controls, take one rising edge, sample 1ns later.
  task automatic cycle(input logic sf, input logic sd, input logic fl,
                       input logic ps, input logic [31:0] tgt);
    StallF    = sf;
    StallD    = sd;
    FlushD    = fl;
    PCSrcE    = ps;
    PCTargetE = tgt;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: next expected PCD on a load, its instruction comes from the ROM.
  task automatic checkLoad(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_pcd"}, PCD, e);
      check({tag, "_pc4"}, PCPlus4D, e + 32'd4);
      check({tag, "_instr"}, InstrD, memWord(e));
      check({tag, "_valid"}, {31'd0, ValidD}, 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    StallF = 1'b1; StallD = 1'b1; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h200, 32'h200};

    repeat (3) @(posedge clk);
    #1;
    check("rst_pcf", PCF, 32'h100);
    check("rst_pcd", PCD, 32'h0);
    check("rst_pc4", PCPlus4D, 32'h0);
    check("rst_valid", {31'd0, ValidD}, 32'd0);
    check("rst_instr", InstrD, 32'h13);
    check("rst_misalign", {31'd0, MisalignF}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_imem_addr", imem_addr, 32'h100);

    // Free run: first two loads
    cycle(1, 1, 0, 0, 0);
    checkLoad("run0");
    check("run0_pcf", PCF, 32'h104);
    cycle(1, 1, 0, 0, 0);
    checkLoad("run1");

    // Full stall for 3 cycles at PCD=0x104
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0);
      check("stall_pcd", PCD, 32'h104);
      check("stall_instr", InstrD, memWord(32'h104));
      check("stall_pcf", PCF, 32'h108);
      check("stall_valid", {31'd0, ValidD}, 32'd1);
    end

    // Release: sequential follow-on, no duplicate
    cycle(1, 1, 0, 0, 0);
    checkLoad("rel0");
    cycle(1, 1, 0, 0, 0);
    checkLoad("rel1");
    check("rel1_pcf", PCF, 32'h110);

    // Taken redirect to 0x200 with flush
    cycle(1, 1, 1, 1, 32'h200);
    check("redir_pcf", PCF, 32'h200);
    check("redir_valid", {31'd0, ValidD}, 32'd0);
    check("redir_instr", InstrD, 32'h13);
    check("redir_pcd", PCD, 32'h0);
    check("redir_misalign", {31'd0, MisalignF}, 32'd0);
    cycle(1, 1, 0, 0, 0);
    checkLoad("tgt");

    // Decode stalled while fetch keeps moving
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("skid_instr", InstrD, memWord(32'h200));
    check("skid_pcd", PCD, 32'h200);
    check("skid_imem_addr", imem_addr, 32'h20C);

    // Misaligned redirect; also resynchronises the fetch stream
    cycle(1, 1, 1, 1, 32'h202);
    check("mis_pcf", PCF, 32'h200);
    check("mis_flag", {31'd0, MisalignF}, 32'd1);
    check("mis_valid", {31'd0, ValidD}, 32'd0);
    cycle(1, 1, 0, 0, 0);
    checkLoad("mis_tgt");
    check("mis_sticky", {31'd0, MisalignF}, 32'd1);
    check("mis_pcf_wrap", PCF, 32'h204);

`ifdef FETCH_PERF_EN
    check("perf_fetch", fetch_cnt, 32'd6);
    check("perf_stall", stall_cnt, 32'd5);
`endif

    // Asynchronous reset in the middle of a stall
    cycle(0, 0, 0, 0, 0);
    check("pre_rst_pcd", PCD, 32'h200);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_pcf", PCF, 32'h100);
    check("arst_pcd", PCD, 32'h0);
    check("arst_valid", {31'd0, ValidD}, 32'd0);
    check("arst_instr", InstrD, 32'h13);
    check("arst_misalign", {31'd0, MisalignF}, 32'd0);
`ifdef FETCH_PERF_EN
    check("arst_fetch_cnt", fetch_cnt, 32'd0);
    check("arst_stall_cnt", stall_cnt, 32'd0);
`endif

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Fetch stage and IF/ID pipeline register of the pipelined RV32I core. Owns the program counter, drives the synchronous instruction memory and presents the decoded-stage instruction, PC and PC+4. Obeys the stall/flush controls from the hazard unit and the branch/jump redirect from Execute. Sits between the hazard unit and the decode stage/register file.

## Interface
- `XLEN`, 32, datapath width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, instruction presented when Decode is invalid (`addi x0,x0,0`).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `StallF`  in  1  active-low enable:
  - 1 = PC advances.
  - 0 = PC holds.
- `StallD`  in  1  active-low enable:
  - 1 = IF/ID loads.
  - 0 = IF/ID holds.
- `FlushD`  in  1  active-high; invalidates IF/ID.
- `PCSrcE`  in  1  redirect request from Execute.
- `PCTargetE`  in  XLEN  redirect target.
- `imem_addr`  out  XLEN  instruction memory address, equal to `PCF`.
- `imem_rdata`  in  32  instruction memory read data; synchronous, one-cycle latency.
- `PCF`  out  XLEN  current fetch PC.
- `InstrD`  out  32  instruction in Decode.
- `PCD`  out  XLEN  PC of `InstrD`.
- `PCPlus4D`  out  XLEN  `PCD`+4.
- `ValidD`  out  1  Decode holds a real instruction.
- `MisalignF`  out  1  sticky: a redirect target had bits [1:0] ≠ 0.

## Operation
- PC update priority, evaluated at each edge:
  1. `PCSrcE`=1 → `PCF` ← `PCTargetE` & ~3. This overrides `StallF`.
  2. `StallF`=0 → `PCF` holds.
  3. Otherwise → `PCF` ← `PCF`+4, modulo 2^XLEN (0xFFFF_FFFC wraps to 0).
- IF/ID update priority, evaluated at each edge:
  1. `FlushD`=1 → `ValidD`←0, `PCD`←0, `PCPlus4D`←0. Flush beats stall.
  2. `StallD`=0 → all IF/ID state holds.
  3. Otherwise → `PCD`←`PCF`, `PCPlus4D`←`PCF`+4, `ValidD`←1.
- Instruction path:
  - `imem_rdata` in cycle n+1 is the word at `imem_addr` of cycle n. It is therefore aligned with `PCD` without any further register.
  - Skid register `instr_hold` and flag `hold_vld`:
    - On an edge where `StallD`=0, `FlushD`=0 and `hold_vld`=0: capture `imem_rdata` and set `hold_vld`.
    - Clear `hold_vld` on any edge where IF/ID loads or flushes.
  - `InstrD` = `ValidD` ? (`hold_vld` ? `instr_hold` : `imem_rdata`) : `NOP_INSTR`.
  - Result: `InstrD` stays stable through a Decode stall even if `imem_addr` moves (for example `StallD`=0 with `StallF`=1, or a redirect during a stall).
- `MisalignF` is set on an edge with `PCSrcE`=1 and `PCTargetE[1:0]`≠0. It clears only on reset.

## Timing
- Reset values: `PCF`=`RESET_PC`, `PCD`=0, `PCPlus4D`=0, `ValidD`=0, `hold_vld`=0, `instr_hold`=0, `MisalignF`=0. `InstrD`=`NOP_INSTR`.
- First edge after reset release: `PCD`=`RESET_PC` and `ValidD`=1. `InstrD` shows mem[`RESET_PC`] in the same cycle.
- Redirect in cycle n:
  - `PCF`=target in n+1.
  - Wrong-path word in n+1 is masked, because the hazard unit asserts `FlushD` with `PCSrcE`.
  - Target instruction reaches Decode in n+2. Branch penalty is 2 cycles.
- Stall: `InstrD`, `PCD` and `ValidD` stay constant for every cycle `StallD`=0. When the stall is released, the next sequential instruction follows with no bubble and no duplicate.
- Asserting reset mid-stall or mid-redirect returns all state to its reset values immediately (asynchronous).

## Configuration
- `FETCH_PERF_EN` defined adds two XLEN-bit wrapping counters, reset to 0, and two extra output ports of the same names:
  - `fetch_cnt` increments on every edge where IF/ID loads with `ValidD` becoming 1.
  - `stall_cnt` increments on every edge with `StallD`=0 and `FlushD`=0.
- `FETCH_PERF_EN` undefined: no counters and no extra ports; behaviour is otherwise identical.

## Structure
- Shared package `core_pkg` holds:
  - `XLEN`.
  - `RESET_PC` default.
  - `NOP_INSTR`.
  - typedef `addr_t` (logic [XLEN-1:0]).
  - typedef `instr_t` (logic [31:0]).
- One sub-module, `pc_reg`, covering the PC register, redirect mux, incrementer and misalign flag.
- The IF/ID register, skid logic and counters live in `fetch_stage`.

## Test plan
- Reset with `RESET_PC`=0x100 and memory holding 0x00500093 at 0x100 → after reset release, `imem_addr`=0x100; one edge later `PCD`=0x100, `PCPlus4D`=0x104, `InstrD`=0x00500093, `ValidD`=1.
- Free run for 4 cycles → `PCD` steps 0x100, 0x104, 0x108, 0x10C, with `InstrD` matching memory each cycle.
- `StallF`=`StallD`=0 for 3 cycles at `PCD`=0x104 → `PCD`, `InstrD` and `PCF`=0x108 are frozen; after release `PCD`=0x108 with no duplicate.
- `PCSrcE`=`FlushD`=1 with `PCTargetE`=0x200 → next cycle `PCF`=0x200, `ValidD`=0, `InstrD`=0x00000013; following cycle `PCD`=0x200.
- `StallD`=0 and `StallF`=1 for 2 cycles → `InstrD` keeps the captured word even though `imem_addr` advances by 8.
- Redirect to 0x202 → `PCF`=0x200, `MisalignF`=1 until `rst_n` is low. With `FETCH_PERF_EN` defined, `stall_cnt` and `fetch_cnt` match the cycle counts of the scenarios above.
